// File: rtl/riscv_core_dpath_vec_wb_assembler_pkg.sv
// Shared definitions for the vector writeback assembler: register geometry,
// FSM encoding and the vector-length clamp.
package riscv_core_dpath_vec_wb_assembler_pkg;

  localparam int VEC_NLANES = 8;
  localparam int VEC_ELEM_W = 32;
  localparam int VEC_REG_W  = VEC_NLANES * VEC_ELEM_W;

  typedef enum logic [1:0] {
    VWB_IDLE    = 2'd0,
    VWB_COLLECT = 2'd1,
    VWB_WRITE   = 2'd2
  } vwb_state_e;

  // Requested lengths beyond the register's lane count saturate at a full register.
  function automatic logic [3:0] vwb_clamp_vl(input logic [3:0] vl);
    return (vl > 4'(VEC_NLANES)) ? 4'(VEC_NLANES) : vl;
  endfunction

endpackage

// File: rtl/riscv_core_dpath_vec_wb_assembler_lane_decode.sv
// Lane index to one-hot lane write-enable decoder used by the staging buffer.
module riscv_core_dpath_vec_lane_decode
  import riscv_core_dpath_vec_wb_assembler_pkg::*;
#(
  parameter int NLANES = VEC_NLANES,
  parameter int IW     = $clog2(NLANES)
) (
  input  logic [IW-1:0]     lane_idx_i,
  input  logic              en_i,
  output logic [NLANES-1:0] lane_we_o
);

  // NOTE: assign every always_comb output a default before any branch so no latch is inferred.
  always_comb begin
    lane_we_o = '0;
    if (en_i) lane_we_o[lane_idx_i] = 1'b1;
  end

endmodule

// File: rtl/riscv_core_dpath_vec_wb_assembler.sv
// Collects vl 32-bit elements into a 256-bit staging buffer and issues one regfile write.
// Build option RISCV_VEC_WB_TAIL_ZERO_EN: clear the buffer on job start so tail lanes write as zero.
module riscv_core_dpath_vec_wb_assembler
  import riscv_core_dpath_vec_wb_assembler_pkg::*;
#(
  parameter int NLANES = VEC_NLANES,
  parameter int ELEM_W = VEC_ELEM_W,
  parameter int AW     = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_val,
  output logic                     start_rdy,
  input  logic [AW-1:0]            start_waddr,
  input  logic [3:0]               start_vl,
  input  logic                     elem_val,
  output logic                     elem_rdy,
  input  logic [ELEM_W-1:0]        elem_data,
  output logic                     wen_p,
  output logic [AW-1:0]            waddr_p,
  output logic [NLANES*ELEM_W-1:0] wdata_p,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(NLANES);

  vwb_state_e               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [3:0]               vl_q, vl_d;
  logic [AW-1:0]            waddr_q, waddr_d;
  logic                     zdone_q, zdone_d;
  logic [NLANES*ELEM_W-1:0] buf_q;
  logic [NLANES-1:0]        lane_we;
  logic [3:0]               vl_clamped;
  logic                     start_fire, elem_fire, last_elem;

  assign vl_clamped = vwb_clamp_vl(start_vl);
  assign start_rdy  = (state_q == VWB_IDLE);
  assign elem_rdy   = (state_q == VWB_COLLECT);
  assign start_fire = start_val && start_rdy;
  assign elem_fire  = elem_val && elem_rdy;
  assign last_elem  = (4'(cnt_q) == vl_q - 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vl_d    = vl_q;
    waddr_d = waddr_q;
    zdone_d = 1'b0;
    unique case (state_q)
      VWB_IDLE: begin
        if (start_val) begin
          vl_d    = vl_clamped;
          waddr_d = start_waddr;
          cnt_d   = '0;
          if (vl_clamped == 4'd0) zdone_d = 1'b1;
          else                    state_d = VWB_COLLECT;
        end
      end
      VWB_COLLECT: begin
        if (elem_val) begin
          cnt_d = cnt_q + CW'(1);
          if (last_elem) begin
            cnt_d   = '0;
            state_d = VWB_WRITE;
          end
        end
      end
      VWB_WRITE: state_d = VWB_IDLE;
      default:   state_d = VWB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= VWB_IDLE;
      cnt_q   <= '0;
      vl_q    <= '0;
      waddr_q <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vl_q    <= vl_d;
      waddr_q <= waddr_d;
      zdone_q <= zdone_d;
    end
  end

  riscv_core_dpath_vec_lane_decode #(
    .NLANES (NLANES)
  ) u_lane_decode (
    .lane_idx_i (cnt_q),
    .en_i       (elem_fire),
    .lane_we_o  (lane_we)
  );

  // NOTE: the staging buffer is reset because tail lanes are visible in the first write after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
    end else begin
`ifdef RISCV_VEC_WB_TAIL_ZERO_EN
      if (start_fire) buf_q <= '0;
`endif
      for (int l = 0; l < NLANES; l++) begin
        if (lane_we[l]) buf_q[l*ELEM_W +: ELEM_W] <= elem_data;
      end
    end
  end

  assign busy    = (state_q != VWB_IDLE);
  assign wen_p   = (state_q == VWB_WRITE);
  assign done    = wen_p || zdone_q;
  assign waddr_p = waddr_q;
  assign wdata_p = buf_q;

endmodule

// File: tb/tb_riscv_core_dpath_vec_wb_assembler.sv
// Self-checking bench: directed scenarios plus randomized jobs against a job-level reference model.
module tb_riscv_core_dpath_vec_wb_assembler;

`ifdef RISCV_VEC_WB_TAIL_ZERO_EN
  localparam bit TAIL_ZERO = 1'b1;
`else
  localparam bit TAIL_ZERO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_val = 1'b0;
  logic         start_rdy;
  logic [4:0]   start_waddr = '0;
  logic [3:0]   start_vl = '0;
  logic         elem_val = 1'b0;
  logic         elem_rdy;
  logic [31:0]  elem_data = '0;
  logic         wen_p;
  logic [4:0]   waddr_p;
  logic [255:0] wdata_p;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_err    = 0;
  int ncyc     = 0;
  int last_wen_n = 0;

  riscv_core_dpath_vec_wb_assembler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_val   (start_val),
    .start_rdy   (start_rdy),
    .start_waddr (start_waddr),
    .start_vl    (start_vl),
    .elem_val    (elem_val),
    .elem_rdy    (elem_rdy),
    .elem_data   (elem_data),
    .wen_p       (wen_p),
    .waddr_p     (waddr_p),
    .wdata_p     (wdata_p),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Job-level reference: a job is either collecting, writing (one cycle) or absent.
  bit          m_active, m_wr, m_zd;
  int          m_got, m_vl, m_start_n;
  logic [4:0]  m_addr;
  logic [31:0] m_lanes [8];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_wr     <= 1'b0;
      m_zd     <= 1'b0;
      m_got    <= 0;
      m_vl     <= 0;
      m_addr   <= '0;
      for (int i = 0; i < 8; i++) m_lanes[i] <= '0;
    end else begin
      m_zd <= 1'b0;
      if (m_wr) begin
        m_wr <= 1'b0;
      end else if (m_active) begin
        if (elem_val) begin
          m_lanes[m_got] <= elem_data;
          m_got <= m_got + 1;
          if (m_got + 1 == m_vl) begin
            m_active <= 1'b0;
            m_wr     <= 1'b1;
          end
        end
      end else if (start_val) begin
        m_addr    <= start_waddr;
        m_vl      <= (int'(start_vl) > 8) ? 8 : int'(start_vl);
        m_got     <= 0;
        m_start_n <= ncyc;
        if (TAIL_ZERO) for (int i = 0; i < 8; i++) m_lanes[i] <= '0;
        if (start_vl == 4'd0) m_zd <= 1'b1;
        else                  m_active <= 1'b1;
      end
    end
  end

  function automatic logic [255:0] model_wdata();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = m_lanes[i];
    return w;
  endfunction

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    check("start_rdy", start_rdy, !m_active && !m_wr);
    check("elem_rdy", elem_rdy, m_active);
    check("busy", busy, m_active || m_wr);
    check("wen_p", wen_p, m_wr);
    check("done", done, m_wr || m_zd);
    if (m_wr) begin
      check("waddr_p", waddr_p, m_addr);
      check("wdata_p", wdata_p, model_wdata());
    end
    if (wen_p) last_wen_n <= ncyc + 1;
  end

  // Drivers: called at a negedge, return at the negedge following the handshake edge.
  task automatic start_job(input logic [4:0] a, input logic [3:0] v);
    bit ok = 1'b0;
    start_val   = 1'b1;
    start_waddr = a;
    start_vl    = v;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = start_rdy;
      @(negedge clk);
    end
    if (!ok) check("start_timeout", 256'd0, 256'd1);
    start_val = 1'b0;
  endtask

  task automatic send_elem(input logic [31:0] d, input int gap);
    bit ok = 1'b0;
    elem_val = 1'b0;
    repeat (gap) @(negedge clk);
    elem_val  = 1'b1;
    elem_data = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = elem_rdy;
      @(negedge clk);
    end
    if (!ok) check("elem_timeout", 256'd0, 256'd1);
    elem_val = 1'b0;
  endtask

  logic [255:0] exp_w;
  logic [4:0]   ra;
  logic [3:0]   rv;
  int           rn;

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("rst_start_rdy", start_rdy, 1'b1);
    check("rst_elem_rdy", elem_rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wen_p", wen_p, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_waddr_p", waddr_p, 5'd0);
    check("rst_wdata_p", wdata_p, 256'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // Full vector, back-to-back elements.
    start_job(5'd5, 4'd8);
    for (int i = 0; i < 8; i++) send_elem(32'h11 * (i + 1), 0);
    check("full_wen", wen_p, 1'b1);
    check("full_done", done, 1'b1);
    check("full_waddr", waddr_p, 5'd5);
    check("full_wdata", wdata_p,
          256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011);
    #1 check("full_latency", 256'(last_wen_n - m_start_n), 256'd9);
    @(negedge clk);
    check("full_wen_one_cycle", wen_p, 1'b0);

    // Partial vector with idle gaps.
    start_job(5'd12, 4'd3);
    send_elem(32'hA, 2);
    send_elem(32'hB, 1);
    send_elem(32'hC, 3);
    for (int i = 0; i < 8; i++)
      exp_w[i*32 +: 32] = (i < 3) ? 32'hA + i : (TAIL_ZERO ? 32'h0 : 32'h11 * (i + 1));
    check("part_wen", wen_p, 1'b1);
    check("part_waddr", waddr_p, 5'd12);
    check("part_wdata", wdata_p, exp_w);
    @(negedge clk);

    // Zero length: done only.
    start_job(5'd3, 4'd0);
    check("vl0_done", done, 1'b1);
    check("vl0_wen", wen_p, 1'b0);
    check("vl0_start_rdy", start_rdy, 1'b1);
    @(negedge clk);

    // vl=12 clamps to 8; extra element is refused.
    start_job(5'd4, 4'd12);
    for (int i = 0; i < 8; i++) send_elem(32'h100 + i, 0);
    check("clamp_wen", wen_p, 1'b1);
    check("clamp_wdata", wdata_p,
          256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100);
    elem_val  = 1'b1;
    elem_data = 32'hDEAD;
    check("clamp_9th_rdy_write", elem_rdy, 1'b0);
    @(negedge clk);
    check("clamp_9th_rdy_idle", elem_rdy, 1'b0);
    @(negedge clk);
    elem_val = 1'b0;

    // Reset mid-job.
    start_job(5'd2, 4'd8);
    for (int i = 0; i < 4; i++) send_elem(32'h200 + i, 0);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_wen", wen_p, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_start_rdy", start_rdy, 1'b1);
    check("midrst_elem_rdy", elem_rdy, 1'b0);
    check("midrst_wdata", wdata_p, 256'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    start_job(5'd6, 4'd1);
    send_elem(32'h5A, 0);
    check("fresh_waddr", waddr_p, 5'd6);
    check("fresh_wdata", wdata_p, 256'h5A);
    @(negedge clk);

    // Back-to-back jobs with start_val held; start during COLLECT is ignored.
    start_job(5'd7, 4'd2);
    start_val   = 1'b1;
    start_waddr = 5'd9;
    start_vl    = 4'd2;
    send_elem(32'h31, 0);
    send_elem(32'h32, 0);
    check("b2b_first_waddr", waddr_p, 5'd7);
    start_job(5'd9, 4'd2);
    #1 check("b2b_start_gap", 256'(m_start_n - last_wen_n), 256'd1);
    send_elem(32'h41, 0);
    send_elem(32'h42, 1);
    check("b2b_second_waddr", waddr_p, 5'd9);
    @(negedge clk);

    // Randomized jobs with protocol noise.
    for (int j = 0; j < 40; j++) begin
      ra = 5'($urandom);
      rv = 4'($urandom_range(0, 15));
      rn = (int'(rv) > 8) ? 8 : int'(rv);
      if ($urandom_range(0, 3) == 0) begin
        elem_val  = 1'b1;
        elem_data = $urandom;
        repeat (2) @(negedge clk);
        elem_val = 1'b0;
      end
      start_job(ra, rv);
      if (rn > 0 && $urandom_range(0, 2) == 0) begin
        start_val   = 1'b1;
        start_waddr = 5'($urandom);
        start_vl    = 4'($urandom);
      end
      for (int k = 0; k < rn; k++) send_elem($urandom, int'($urandom_range(0, 2)));
      start_val = 1'b0;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
